// File: rtl/dram_block_arbiter.sv
// dram_block_arbiter
//   Arbitrates the shared block-wide DRAM between the I-cache (block reads
//   only) and the D-cache (block reads and write-backs). It accepts one whole
//   block transaction at a time, issues a single-cycle DRAM command, waits a
//   fixed latency, then returns the block with a one-cycle acknowledge.
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   i_req/i_addr      : I-cache block read request and block address
//   i_ack/i_rdata     : I-cache completion pulse and refill block
//   d_req/d_we/d_addr/d_wdata : D-cache request, write flag, address, data
//   d_ack/d_rdata     : D-cache completion pulse and refill block
//   mem_wren/mem_rden : DRAM write/read strobes (high only in the CMD cycle)
//   mem_addr/mem_wdata: DRAM block address and write data (held between
//                       transactions)
//   mem_rdata         : DRAM read data, valid MEM_LAT cycles after CMD
//   busy              : high whenever a transaction is in flight
module dram_block_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 128,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_wren,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT) + 1;

  typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  // last_grant_q also identifies the owner of the transaction in flight,
  // since it is written with the winner on the way into CMD. 1 = D-cache.
  logic                last_grant_q, last_grant_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                mem_wren_q, mem_wren_d;
  logic                mem_rden_q, mem_rden_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                pick_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_wren_d   = 1'b0;
    mem_rden_d   = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    // D wins when it is alone, or on a tie when I-cache had the last grant.
    pick_d       = d_req & (~i_req | ~last_grant_q);

    case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          last_grant_d = pick_d;
          we_d         = pick_d & d_we;
          mem_addr_d   = pick_d ? d_addr : i_addr;
          if (pick_d) begin
            mem_wdata_d = d_wdata;
          end
          // Strobes are registered, so they are raised here to be high
          // exactly during the CMD cycle.
          mem_wren_d   = pick_d & d_we;
          mem_rden_d   = ~(pick_d & d_we);
          state_d      = CMD;
        end
      end
      CMD: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (!we_q) begin
            if (last_grant_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              i_rdata_d = mem_rdata;
            end
          end
          // Ack registered here so it is high during the RESP cycle.
          d_ack_d = last_grant_q;
          i_ack_d = ~last_grant_q;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      mem_wren_q   <= 1'b0;
      mem_rden_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_wren_q   <= mem_wren_d;
      mem_rden_q   <= mem_rden_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_wren  = mem_wren_q;
  assign mem_rden  = mem_rden_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: doc/dram_block_arbiter.md
# dram_block_arbiter

Two-port arbiter and sequencer for the shared 128-bit block-wide DRAM. It sits between the instruction cache (read-only block refills) and the data cache (refills and dirty-block write-backs) and owns the DRAM `wren`/`rden`/`addr`/`data_in` pins. It accepts one whole-block transaction at a time, arbitrates round-robin, drives a single-cycle command, waits a fixed memory latency, then returns the data with a one-cycle acknowledge.

## Interface
- `ADDR_W`, 23: block address width (byte address = `{addr, 4'b0000}`).
- `DATA_W`, 128: block width.
- `MEM_LAT`, 1: cycles from the DRAM command cycle until `mem_rdata` is valid. Must be ≥1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_req` in 1: I-cache block-read request; held until `i_ack`.
- `i_addr` in ADDR_W: I-cache block address.
- `i_ack` out 1: one-cycle completion pulse.
- `i_rdata` out DATA_W: refill block; valid while `i_ack`=1.
- `d_req` in 1: D-cache request; held with `d_we`/`d_addr`/`d_wdata` stable until `d_ack`.
- `d_we` in 1: 1 = write-back, 0 = refill.
- `d_addr` in ADDR_W: D-cache block address.
- `d_wdata` in DATA_W: write-back block.
- `d_ack` out 1: one-cycle completion pulse.
- `d_rdata` out DATA_W: refill block; valid while `d_ack`=1.
- `mem_wren` out 1: DRAM write strobe.
- `mem_rden` out 1: DRAM read strobe.
- `mem_addr` out ADDR_W: DRAM block address.
- `mem_wdata` out DATA_W: DRAM write data.
- `mem_rdata` in DATA_W: DRAM read data.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, CMD, WAIT, RESP.
- **IDLE:** if any request is present, select the winner, latch its address, write flag and write data, record it as the grant, and go to CMD. Otherwise stay in IDLE.
- **Arbitration:**
  - A single requester always wins.
  - When both request, the requester not granted last wins.
  - The `last_grant` register resets to I-cache, so the first tie goes to the D-cache.
  - `last_grant` updates only when entering CMD.
- **CMD:** exactly one cycle. Assert `mem_rden` (read) or `mem_wren` (write) with `mem_addr` and `mem_wdata` from the latched values. Load the latency counter with `MEM_LAT-1`, then go to WAIT.
- **WAIT:**
  - When the counter is nonzero, decrement it.
  - When the counter is 0 and the transaction is a read, capture `mem_rdata` into the granted requester's rdata register.
  - When the counter is 0, go to RESP. Writes take the same path for uniform timing.
- **RESP:** pulse the granted requester's ack for one cycle, then go to IDLE.
- **Strobe exclusivity:** `mem_wren` and `mem_rden` are never high together, and both are 0 outside CMD.
- **Data and address holding:** `i_rdata`/`d_rdata` hold their last captured value; a write never modifies them. `mem_addr`/`mem_wdata` hold their latched values between transactions.
- **Request changes:** requests arriving or dropping while `busy`=1 are ignored until IDLE. Inputs are sampled only in IDLE.
- **Counter width:** the latency counter is `$clog2(MEM_LAT)+1` bits, with no wrap-around.

## Timing
- **Reset:** on `rst`=0, immediately:
  - state = IDLE, `last_grant` = I-cache, counter = 0.
  - All outputs are 0: `i_ack`, `d_ack`, `i_rdata`, `d_rdata`, `mem_wren`, `mem_rden`, `mem_addr`, `mem_wdata`, `busy`.
- **Reset mid-transaction:** the transaction is abandoned and no ack is issued. A write whose CMD cycle already occurred may have updated DRAM. The requester re-requests after reset.
- **Latency:** with request sampled in IDLE at cycle 0:
  - CMD is cycle 1.
  - WAIT spans cycles 2 to MEM_LAT+1.
  - Ack is in cycle MEM_LAT+2 (cycle 3 at the default).
  - IDLE is in cycle MEM_LAT+3.
- **Throughput:** one transaction per MEM_LAT+3 cycles.
- **Requester rule:** deassert or replace the request in the cycle after ack. A request still high in the IDLE cycle after ack is treated as a new transaction.
- **Back-to-back:** if both request continuously, grants alternate D, I, D, I, …

## Test plan
- **Reset values:** hold `rst`=0 with random inputs → all outputs 0; release → `busy`=0 and no strobe.
- **I-cache refill:** `i_req`=1, `i_addr`=23'h000010 at cycle 0 → `mem_rden`=1 and `mem_addr`=23'h10 in cycle 1 only; `i_ack`=1 in cycle 3 with `i_rdata` equal to DRAM bytes 0x100–0x10F; `d_ack` stays 0.
- **D-cache write then read:** write-back to 23'h2A with data 128'hDEADBEEF_… → `mem_wren` for one cycle and `d_ack` at cycle 3 with `d_rdata` unchanged; refill of 23'h2A → `d_rdata` equals the written data.
- **Simultaneous requests:** both request from reset, held continuously → D-cache acked first, then I-cache, then D-cache; one ack per 4 cycles; never both acks high together.
- **Latency parameter:** instantiate with MEM_LAT=4 → ack exactly 6 cycles after the request is sampled; `mem_rden` high in exactly one cycle.
- **Reset mid-transaction:** assert `rst` during WAIT → no ack ever issued for that transaction; after release, a new `i_req` completes normally with ack at cycle 3.
